// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide sequencer:
//   - ALUOP_* opcodes for the ops the sequencer owns
//   - FSM state encoding
//   - decode helpers (is_mul / is_div / is_signed) and a 32-bit
//     count-leading-zeros helper used by the early-terminating divider
//     (MULDIV_DIV_EARLY_TERM_EN).
package muldiv_ctrl_pkg;

  localparam logic [7:0] ALUOP_MULT  = 8'b0001_1000;
  localparam logic [7:0] ALUOP_MULTU = 8'b0001_1001;
  localparam logic [7:0] ALUOP_DIV   = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] ALUOP_MADD  = 8'b1010_0110;
  localparam logic [7:0] ALUOP_MADDU = 8'b1010_1000;
  localparam logic [7:0] ALUOP_MUL   = 8'b1010_1001;
  localparam logic [7:0] ALUOP_MSUB  = 8'b1010_1010;
  localparam logic [7:0] ALUOP_MSUBU = 8'b1010_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic muldiv_op_is_mul(input logic [7:0] op);
    case (op)
      ALUOP_MULT, ALUOP_MULTU, ALUOP_MUL,
      ALUOP_MADD, ALUOP_MADDU, ALUOP_MSUB, ALUOP_MSUBU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic muldiv_op_is_div(input logic [7:0] op);
    return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
  endfunction

  function automatic logic muldiv_op_is_signed(input logic [7:0] op);
    case (op)
      ALUOP_MULT, ALUOP_MUL, ALUOP_MADD, ALUOP_MSUB, ALUOP_DIV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Number of leading zeros; 32 for a zero input.
  function automatic logic [5:0] muldiv_clz32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
// EXE-stage <-> muldiv sequencer bundle.
//   master (EXE):    drives start, aluop, src0, src1, hilo_i, flush;
//                    receives stall_o, done, hilo_we, hilo_wdata,
//                    gpr_result, div_zero.
//   slave (muldiv):  the mirror image.
interface muldiv_ctrl_if;
  logic        start;
  logic [7:0]  aluop;
  logic [31:0] src0;
  logic [31:0] src1;
  logic [63:0] hilo_i;
  logic        flush;
  logic        stall_o;
  logic        done;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic [31:0] gpr_result;
  logic        div_zero;

  modport master (
    output start, aluop, src0, src1, hilo_i, flush,
    input  stall_o, done, hilo_we, hilo_wdata, gpr_result, div_zero
  );

  modport slave (
    input  start, aluop, src0, src1, hilo_i, flush,
    output stall_o, done, hilo_we, hilo_wdata, gpr_result, div_zero
  );
endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core
// Iterative restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   abort             drop any division in progress (pipeline flush)
//   start             load operands and begin (divisor must be non-zero)
//   is_signed         DIV semantics (magnitudes + sign fix) vs DIVU
//   dividend, divisor operands, sampled on start
//   busy              division in progress
//   done              final iteration happens this cycle; quotient and
//                     remainder are valid in the same cycle
//   quotient, remainder  sign-corrected results of the current step
// Build option: MULDIV_DIV_EARLY_TERM_EN skips the leading zero bits of
// the dividend magnitude (pre-shifted at start, 32-clz iterations, >=1).
module muldiv_div_core
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dvd_reg;   // dividend bits shifting out, quotient bits in
  logic [31:0] dvs_reg;
  logic [31:0] rem_reg;
  logic [5:0]  cnt_reg;
  logic [5:0]  last_reg;
  logic        busy_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;

  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvd_init;
  logic [5:0]  last_init;

  always_comb begin
    dvd_mag = (is_signed && dividend[31]) ? -dividend : dividend;
    dvs_mag = (is_signed && divisor[31])  ? -divisor  : divisor;
  end

`ifdef MULDIV_DIV_EARLY_TERM_EN
  logic [5:0] lz;
  always_comb begin
    lz        = muldiv_clz32(dvd_mag);
    dvd_init  = dvd_mag << lz;
    // zero dividend still runs one iteration
    last_init = (lz >= 6'(DIV_ITER)) ? 6'd0 : 6'(DIV_ITER - 1) - lz;
  end
`else
  always_comb begin
    dvd_init  = dvd_mag;
    last_init = 6'(DIV_ITER - 1);
  end
`endif

  // One restoring step. The remainder never reaches the divisor, so
  // the shifted partial needs 33 bits but a successful subtraction
  // always fits back into 32.
  logic [32:0] partial;
  logic        q_bit;
  logic [31:0] diff;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  always_comb begin
    partial  = {rem_reg, dvd_reg[31]};
    q_bit    = (partial >= {1'b0, dvs_reg});
    diff     = partial[31:0] - dvs_reg;
    rem_step = q_bit ? diff : partial[31:0];
    quo_step = {dvd_reg[30:0], q_bit};
  end

  // Negating 0x80000000 leaves it unchanged, which gives the
  // 0x80000000 / -1 result without any special case.
  assign quotient  = neg_q_reg ? -quo_step : quo_step;
  assign remainder = neg_r_reg ? -rem_step : rem_step;
  assign busy      = busy_reg;
  assign done      = busy_reg && (cnt_reg == last_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      last_reg  <= '0;
      busy_reg  <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (abort) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      dvd_reg   <= dvd_init;
      dvs_reg   <= dvs_mag;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      last_reg  <= last_init;
      busy_reg  <= 1'b1;
      neg_q_reg <= is_signed && (dividend[31] ^ divisor[31]);
      neg_r_reg <= is_signed && dividend[31];
    end else if (busy_reg) begin
      dvd_reg <= quo_step;
      rem_reg <= rem_step;
      if (done) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 6'd1;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Multi-cycle sequencer for HI/LO ops in EXE: MULT/MULTU/MUL/MADD/MADDU/
// MSUB/MSUBU (held MUL_STAGES cycles) and DIV/DIVU (iterative divider).
// Stalls IF..EXE while busy and presents the result in a one-cycle DONE
// slot.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  start/aluop/src0/src1/hilo_i/flush in;
//                stall_o (combinational), done, hilo_we, hilo_wdata,
//                gpr_result, div_zero (registered) out
// Build option: MULDIV_DIV_EARLY_TERM_EN (see muldiv_div_core).
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int DIV_ITER   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_STAGES - 1);

  muldiv_state_e state_reg, state_next;

  logic [2:0]  cnt_reg;
  logic [7:0]  op_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [63:0] hilo_base_reg;

  logic        done_reg;
  logic        hilo_we_reg;
  logic        div_zero_reg;
  logic [63:0] hilo_wdata_reg;
  logic [31:0] gpr_result_reg;

  logic accept;
  logic in_is_div;
  logic div_start;
  logic stall;

  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign in_is_div = muldiv_op_is_div(bus.aluop);
  assign accept    = (state_reg == ST_IDLE) && bus.start && !bus.flush &&
                     (muldiv_op_is_mul(bus.aluop) || in_is_div);
  // a zero divisor never reaches the divider
  assign div_start = accept && in_is_div && (bus.src1 != 32'd0);

  muldiv_div_core #(
    .DIV_ITER (DIV_ITER)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (bus.flush),
    .start     (div_start),
    .is_signed (bus.aluop == ALUOP_DIV),
    .dividend  (bus.src0),
    .divisor   (bus.src1),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Multiply datapath, combinational from the latched operands. The MUL
  // state holds the operands stable for MUL_STAGES cycles, so this path
  // is given that many cycles to settle before it is captured.
  logic        mul_signed;
  logic        mul_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [63:0] mul_result;

  always_comb begin
    mul_signed = muldiv_op_is_signed(op_reg);
    mul_neg    = mul_signed && (a_reg[31] ^ b_reg[31]);
    a_mag      = (mul_signed && a_reg[31]) ? -a_reg : a_reg;
    b_mag      = (mul_signed && b_reg[31]) ? -b_reg : b_reg;
    prod_mag   = 64'(a_mag) * 64'(b_mag);
    prod       = mul_neg ? -prod_mag : prod_mag;
    case (op_reg)
      ALUOP_MADD, ALUOP_MADDU: mul_result = hilo_base_reg + prod;
      ALUOP_MSUB, ALUOP_MSUBU: mul_result = hilo_base_reg - prod;
      default:                 mul_result = prod;
    endcase
  end

  // Next state and stall
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (!in_is_div)                state_next = ST_MUL;
          else if (bus.src1 == 32'd0)    state_next = ST_DONE;
          else                           state_next = ST_DIV;
        end
      end
      ST_MUL: begin
        stall = 1'b1;
        if (cnt_reg == MUL_LAST) state_next = ST_DONE;
      end
      ST_DIV: begin
        stall = 1'b1;
        if (div_done)       state_next = ST_DONE;
        else if (!div_busy) state_next = ST_IDLE;  // divider lost; recover
      end
      ST_DONE: state_next = ST_IDLE;  // start ignored: no re-issue
      default: state_next = ST_IDLE;
    endcase
    if (bus.flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      hilo_base_reg  <= '0;
      done_reg       <= 1'b0;
      hilo_we_reg    <= 1'b0;
      div_zero_reg   <= 1'b0;
      hilo_wdata_reg <= '0;
      gpr_result_reg <= '0;
    end else begin
      cnt_reg <= (state_reg == ST_MUL && state_next == ST_MUL) ?
                 cnt_reg + 3'd1 : 3'd0;
      if (accept) begin
        op_reg        <= bus.aluop;
        a_reg         <= bus.src0;
        b_reg         <= bus.src1;
        hilo_base_reg <= bus.hilo_i;
      end
      // flush forces state_next to IDLE, so a flush cycle never loads
      // a result slot for the following cycle
      done_reg     <= (state_next == ST_DONE);
      hilo_we_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      if (state_next == ST_DONE) begin
        case (state_reg)
          ST_IDLE: div_zero_reg <= 1'b1;  // divide by zero, HI/LO untouched
          ST_MUL: begin
            if (op_reg == ALUOP_MUL) begin
              gpr_result_reg <= mul_result[31:0];
            end else begin
              hilo_we_reg    <= 1'b1;
              hilo_wdata_reg <= mul_result;
            end
          end
          ST_DIV: begin
            hilo_we_reg    <= 1'b1;
            hilo_wdata_reg <= {div_rem, div_quo};
          end
          default: ;
        endcase
      end
    end
  end

  // A flush landing on the DONE slot itself must still suppress the
  // write, so the slot strobes are masked by the live flush.
  assign bus.stall_o    = stall;
  assign bus.done       = done_reg     && !bus.flush;
  assign bus.hilo_we    = hilo_we_reg  && !bus.flush;
  assign bus.div_zero   = div_zero_reg && !bus.flush;
  assign bus.hilo_wdata = hilo_wdata_reg;
  assign bus.gpr_result = gpr_result_reg;

endmodule
